// File: rtl/inst_buffer_pkg.sv
// Shared constants and types for the fetch-to-decode instruction buffer.
package inst_buffer_pkg;

    localparam int          INST_BUF_DEPTH = 16;
    localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;
    localparam logic        FLUSH          = 1'b1;

    typedef enum logic {
        SINGLE_ISSUE = 1'b0,
        DUAL_ISSUE   = 1'b1
    } issue_mode_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

endpackage

// File: rtl/inst_buffer.sv
// Dual-issue instruction queue: fetch pushes 0-2 entries per cycle, decode pops 1-2.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH  = INST_BUF_DEPTH,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              flush_keep_ds_i,
    input  logic              stall_i,
    input  logic              push1_valid_i,
    input  logic              push2_valid_i,
    input  logic [31:0]       push1_inst_i,
    input  logic [31:0]       push2_inst_i,
    input  logic [31:0]       push1_pc_i,
    input  logic [31:0]       push2_pc_i,
    input  logic              issue_en_i,
    input  logic              issue_mode_i,
    output logic [31:0]       inst1_o,
    output logic [31:0]       inst2_o,
    output logic [31:0]       pc1_o,
    output logic [31:0]       pc2_o,
    output logic              inst1_valid_o,
    output logic              inst2_valid_o,
    output logic              full_o,
    output logic [ADDR_W:0]   count_o
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_W   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] TWO_W   = (ADDR_W+1)'(2);

    entry_t mem [DEPTH];

    logic [ADDR_W-1:0] head, tail, head_n, tail_n, head_p1, tail_p1;
    logic [ADDR_W:0]   count, count_n, push_n, pop_n;
    logic              full, flushing, do_push1, do_push2, pop_en;

    assign head_p1  = head + 1'b1;
    assign tail_p1  = tail + 1'b1;
    assign full     = (DEPTH_W - count) < TWO_W;
    assign flushing = (flush_i == FLUSH);

    // A push while full is dropped as a whole pair, never split.
    assign do_push1 = push1_valid_i & ~full & ~flushing;
    assign do_push2 = push2_valid_i & do_push1;
    assign pop_en   = issue_en_i & ~stall_i & ~flushing;

    always_comb begin
        push_n  = (ADDR_W+1)'(do_push1) + (ADDR_W+1)'(do_push2);
        pop_n   = '0;
        if (pop_en) begin
            if (issue_mode_i == DUAL_ISSUE && count >= TWO_W) begin
                pop_n = TWO_W;
            end else if (count >= ONE_W) begin
                pop_n = ONE_W;
            end
        end
        head_n  = head + pop_n[ADDR_W-1:0];
        tail_n  = tail + push_n[ADDR_W-1:0];
        count_n = count + push_n - pop_n;
        if (flushing) begin
            // Keeping the delay slot collapses the queue to just the head entry.
            if (flush_keep_ds_i && count != '0) begin
                head_n  = head;
                tail_n  = head_p1;
                count_n = ONE_W;
            end else begin
                head_n  = '0;
                tail_n  = '0;
                count_n = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head_n;
            tail  <= tail_n;
            count <= count_n;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push1) mem[tail]    <= {push1_inst_i, push1_pc_i};
        if (do_push2) mem[tail_p1] <= {push2_inst_i, push2_pc_i};
    end

    always_comb begin
        inst1_o = ZERO_WORD;
        pc1_o   = ZERO_WORD;
        inst2_o = ZERO_WORD;
        pc2_o   = ZERO_WORD;
        if (count >= ONE_W) begin
            inst1_o = mem[head].inst;
            pc1_o   = mem[head].pc;
        end
        if (count >= TWO_W) begin
            inst2_o = mem[head_p1].inst;
            pc2_o   = mem[head_p1].pc;
        end
    end

    assign inst1_valid_o = (count >= ONE_W);
    assign inst2_valid_o = (count >= TWO_W);
    assign full_o        = full;
    assign count_o       = count;

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer: queue-based reference model plus directed scenarios.
module tb_inst_buffer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush_i, flush_keep_ds_i, stall_i;
    logic        push1_valid_i, push2_valid_i;
    logic [31:0] push1_inst_i, push2_inst_i, push1_pc_i, push2_pc_i;
    logic        issue_en_i, issue_mode_i;
    logic [31:0] inst1_o, inst2_o, pc1_o, pc2_o;
    logic        inst1_valid_o, inst2_valid_o, full_o;
    logic [4:0]  count_o;

    inst_buffer #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .flush_i(flush_i), .flush_keep_ds_i(flush_keep_ds_i),
        .stall_i(stall_i), .push1_valid_i(push1_valid_i), .push2_valid_i(push2_valid_i),
        .push1_inst_i(push1_inst_i), .push2_inst_i(push2_inst_i),
        .push1_pc_i(push1_pc_i), .push2_pc_i(push2_pc_i),
        .issue_en_i(issue_en_i), .issue_mode_i(issue_mode_i),
        .inst1_o(inst1_o), .inst2_o(inst2_o), .pc1_o(pc1_o), .pc2_o(pc2_o),
        .inst1_valid_o(inst1_valid_o), .inst2_valid_o(inst2_valid_o),
        .full_o(full_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    bit          cmp_en = 1'b0;
    logic [63:0] q[$];
    int          head_idx = 0;
    int          m_sz, m_n;
    logic [63:0] m_keep;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {inst,pc}; head_idx is the logical slot of the head.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            head_idx = 0;
        end else if (flush_i) begin
            if (flush_keep_ds_i && q.size() > 0) begin
                m_keep = q[0];
                q.delete();
                q.push_back(m_keep);
            end else begin
                q.delete();
                head_idx = 0;
            end
        end else begin
            m_sz = q.size();
            if (issue_en_i && !stall_i) begin
                m_n = issue_mode_i ? 2 : 1;
                if (m_n > m_sz) m_n = m_sz;
                repeat (m_n) void'(q.pop_front());
                head_idx = (head_idx + m_n) % DEPTH;
            end
            if (DEPTH - m_sz >= 2) begin
                if (push1_valid_i) q.push_back({push1_inst_i, push1_pc_i});
                if (push1_valid_i && push2_valid_i) q.push_back({push2_inst_i, push2_pc_i});
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            check("count", 64'(count_o), 64'(q.size()));
            check("full", 64'(full_o), 64'((DEPTH - q.size()) < 2));
            check("valid1", 64'(inst1_valid_o), 64'(q.size() >= 1));
            check("valid2", 64'(inst2_valid_o), 64'(q.size() >= 2));
            if (q.size() >= 1) check("head1", {inst1_o, pc1_o}, q[0]);
            else               check("head1_zero", {inst1_o, pc1_o}, 64'h0);
            if (q.size() >= 2) check("head2", {inst2_o, pc2_o}, q[1]);
            else               check("head2_zero", {inst2_o, pc2_o}, 64'h0);
        end
    end

    task automatic drive(input logic p1, input logic p2,
                         input logic [31:0] i1, input logic [31:0] a1,
                         input logic [31:0] i2, input logic [31:0] a2,
                         input logic ie, input logic im, input logic st,
                         input logic fl, input logic fk);
        push1_valid_i = p1;  push2_valid_i = p2;
        push1_inst_i  = i1;  push1_pc_i    = a1;
        push2_inst_i  = i2;  push2_pc_i    = a2;
        issue_en_i    = ie;  issue_mode_i  = im;
        stall_i       = st;  flush_i       = fl;  flush_keep_ds_i = fk;
        @(negedge clk);
        push1_valid_i = 1'b0; push2_valid_i = 1'b0;
        issue_en_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0; flush_keep_ds_i = 1'b0;
    endtask

    task automatic push_pair(input logic [31:0] i1, input logic [31:0] a1,
                             input logic [31:0] i2, input logic [31:0] a2);
        drive(1, 1, i1, a1, i2, a2, 0, 0, 0, 0, 0);
    endtask

    task automatic push_one(input logic [31:0] i1, input logic [31:0] a1);
        drive(1, 0, i1, a1, 32'h0, 32'h0, 0, 0, 0, 0, 0);
    endtask

    task automatic issue(input logic dual);
        drive(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, dual, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        flush_i = 0; flush_keep_ds_i = 0; stall_i = 0;
        push1_valid_i = 0; push2_valid_i = 0;
        push1_inst_i = 0; push2_inst_i = 0; push1_pc_i = 0; push2_pc_i = 0;
        issue_en_i = 0; issue_mode_i = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cmp_en = 1'b1;

        check("rst_count", 64'(count_o), 64'd0);
        check("rst_valid1", 64'(inst1_valid_o), 64'd0);
        check("rst_full", 64'(full_o), 64'd0);

        // basic push then dual issue
        push_pair(32'h2401_0001, 32'hBFC0_0000, 32'h2402_0002, 32'hBFC0_0004);
        check("p_valid2", 64'(inst2_valid_o), 64'd1);
        check("p_head1", {inst1_o, pc1_o}, 64'h2401_0001_BFC0_0000);
        check("p_head2", {inst2_o, pc2_o}, 64'h2402_0002_BFC0_0004);
        issue(1);
        check("pop_count", 64'(count_o), 64'd0);
        check("pop_valid1", 64'(inst1_valid_o), 64'd0);

        // fill to full, push ignored, single issue
        for (int i = 0; i < 8; i++)
            push_pair(32'h1000 + 32'(2*i), 32'h100 + 32'(8*i), 32'h1001 + 32'(2*i), 32'h104 + 32'(8*i));
        check("fill_count", 64'(count_o), 64'd16);
        check("fill_full", 64'(full_o), 64'd1);
        push_pair(32'hDEAD_0001, 32'h0, 32'hDEAD_0002, 32'h4);
        check("full_push_ign", 64'(count_o), 64'd16);
        issue(0);
        check("single_pop", 64'(count_o), 64'd15);
        check("single_head", 64'(inst1_o), 64'h1001);
        for (int i = 0; i < 7; i++) issue(1);
        check("drain_count", 64'(count_o), 64'd1);
        issue(1);
        check("overreq_count", 64'(count_o), 64'd0);
        check("overreq_valid", 64'(inst1_valid_o), 64'd0);

        // walk head to slot 14 on an empty queue, then straddle the wrap
        for (int k = 0; k < 16 && head_idx != 14; k++) begin
            push_one(32'h5000 + 32'(k), 32'h0);
            issue(0);
        end
        check("model_head14", 64'(head_idx), 64'd14);
        push_pair(32'hAAAA_0014, 32'h0000_0014, 32'hBBBB_0015, 32'h0000_0015);
        issue(0);
        push_one(32'hCCCC_0000, 32'h0000_0100);
        check("model_head15", 64'(head_idx), 64'd15);
        check("wrap_head1", {inst1_o, pc1_o}, 64'hBBBB_0015_0000_0015);
        check("wrap_head2", {inst2_o, pc2_o}, 64'hCCCC_0000_0000_0100);
        issue(1);
        check("model_head1", 64'(head_idx), 64'd1);
        check("wrap_count", 64'(count_o), 64'd0);

        // mispredict flush keeping delay slot, with colliding push and issue
        push_pair(32'h7000_0001, 32'h8000_1004, 32'h7000_0002, 32'h8000_1008);
        push_pair(32'h7000_0003, 32'h8000_100C, 32'h7000_0004, 32'h8000_1010);
        push_one(32'h7000_0005, 32'h8000_1014);
        check("ds_pre_count", 64'(count_o), 64'd5);
        drive(1, 1, 32'hEEEE_0001, 32'h9000_0000, 32'hEEEE_0002, 32'h9000_0004, 1, 1, 0, 1, 1);
        check("ds_count", 64'(count_o), 64'd1);
        check("ds_pc1", 64'(pc1_o), 64'h8000_1004);
        check("ds_valid2", 64'(inst2_valid_o), 64'd0);
        push_one(32'h7100_0000, 32'h8000_2000);
        check("ds_after_push", {inst2_o, pc2_o}, 64'h7100_0000_8000_2000);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("flush_count", 64'(count_o), 64'd0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            automatic logic p1 = ($urandom_range(0, 3) != 0);
            automatic logic p2 = p1 && ($urandom_range(0, 1) == 1);
            drive(p1, p2, $urandom, $urandom, $urandom, $urandom,
                  $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0,
                  1'($urandom_range(0, 1)));
        end

        // asynchronous reset mid-stream
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) push_pair(32'h3000 + 32'(i), 32'h0, 32'h3100 + 32'(i), 32'h4);
        push_one(32'h3200, 32'h8);
        check("mid_count", 64'(count_o), 64'd7);
        #2 reset = 1'b1;
        #1;
        check("async_count", 64'(count_o), 64'd0);
        check("async_valid1", 64'(inst1_valid_o), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        push_one(32'h2401_0001, 32'hBFC0_0000);
        check("post_rst_valid", 64'(inst1_valid_o), 64'd1);
        check("post_rst_head", {inst1_o, pc1_o}, 64'h2401_0001_BFC0_0000);
        check("post_rst_count", 64'(count_o), 64'd1);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
